// File: rtl/cla_nibble_seq_ctrl.sv
// rtl/cla_nibble_seq_ctrl.sv - multi-cycle WIDTH-bit add/sub sequencer built on one 4-bit CLA slice
module cla_nibble_seq_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int IDX_W   = $clog2(NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             overflow_q, overflow_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic [3:0] nib_a, nib_b, g, p, s;
  logic       c1, c2, c3, c4;

  // 4-bit lookahead slice fed by the current nibble and the carry register
  always_comb begin
    nib_a = a_q[4*idx_q +: 4];
    nib_b = b_q[4*idx_q +: 4];
    g     = nib_a & nib_b;
    p     = nib_a ^ nib_b;
    c1    = g[0] | (p[0] & carry_q);
    c2    = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry_q);
    c3    = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & carry_q);
    c4    = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
          | (p[3] & p[2] & p[1] & p[0] & carry_q);
    s     = p ^ {c3, c2, c1, carry_q};
  end

  // next-state and registered-output logic; subtraction is folded in at accept time
  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    overflow_d  = overflow_q;
    a_d         = a_q;
    b_d         = b_q;
    carry_d     = carry_q;
    idx_d       = idx_q;
    case (state_q)
      IDLE: begin
        in_ready_d = 1'b1;
        if (in_valid && in_ready_q) begin
          a_d        = a;
          b_d        = b ^ {WIDTH{sub}};
          carry_d    = sub | cin;
          idx_d      = '0;
          in_ready_d = 1'b0;
          state_d    = RUN;
        end
      end
      RUN: begin
        sum_d[4*idx_q +: 4] = s;
        carry_d             = c4;
        idx_d               = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          cout_d      = c4;
          overflow_d  = c3 ^ c4;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // state and datapath registers; reset abandons any operation in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      overflow_q  <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      overflow_q  <= overflow_d;
      a_q         <= a_d;
      b_q         <= b_d;
      carry_q     <= carry_d;
      idx_q       <= idx_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_cla_nibble_seq_ctrl.sv
// tb/tb_cla_nibble_seq_ctrl.sv - directed self-checking bench for cla_nibble_seq_ctrl
module tb_cla_nibble_seq_ctrl;

  localparam int WIDTH = 16;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  int n_assert = 0;
  int n_fail   = 0;

  cla_nibble_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic tcin,
                        input logic tsub, input logic [15:0] esum, input logic ecout,
                        input logic eov, input int hold);
    int cyc;
    cyc = 0;
    while (in_ready !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("in_ready_before_accept", 32'(in_ready), 32'(1));
    a        = ta;
    b        = tb_v;
    cin      = tcin;
    sub      = tsub;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    a   = 16'($urandom);
    b   = 16'($urandom);
    cin = 1'($urandom);
    sub = 1'($urandom);
    cyc = 0;
    do begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end while (out_valid !== 1'b1 && cyc < 20);
    check("latency", 32'(cyc), 32'(4));
    check("sum", 32'(sum), 32'(esum));
    check("cout", 32'(cout), 32'(ecout));
    check("overflow", 32'(overflow), 32'(eov));
    check("in_ready_while_valid", 32'(in_ready), 32'(0));
    for (int i = 0; i < hold; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      @(negedge clk);
      check("hold_out_valid", 32'(out_valid), 32'(1));
      check("hold_in_ready", 32'(in_ready), 32'(0));
      check("hold_sum", 32'(sum), 32'(esum));
      check("hold_flags", 32'({cout, overflow}), 32'({ecout, eov}));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    @(negedge clk);
    check("post_handshake_out_valid", 32'(out_valid), 32'(0));
    check("post_handshake_in_ready", 32'(in_ready), 32'(1));
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    sub       = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'(0));
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_sum", 32'(sum), 32'(0));
    check("rst_cout", 32'(cout), 32'(0));
    check("rst_overflow", 32'(overflow), 32'(0));
    rst = 1'b0;
    #1;
    check("in_ready_before_first_edge", 32'(in_ready), 32'(0));
    @(negedge clk);
    check("in_ready_after_first_edge", 32'(in_ready), 32'(1));

    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 0);
    run_op(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 0);
    run_op(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 10);
    run_op(16'h0001, 16'h0002, 1'b1, 1'b0, 16'h0004, 1'b0, 1'b0, 0);
    run_op(16'hA5A5, 16'h5A5A, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
    run_op(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 0);

    a        = 16'h1111;
    b        = 16'h1111;
    cin      = 1'b0;
    sub      = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrun_rst_out_valid", 32'(out_valid), 32'(0));
    check("midrun_rst_sum", 32'(sum), 32'(0));
    check("midrun_rst_in_ready", 32'(in_ready), 32'(0));
    check("midrun_rst_cout", 32'(cout), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_midrun_rst", 32'(in_ready), 32'(1));
    run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
